// File: rtl/theta_sr1_alignment_detector.sv
// theta_sr1_alignment_detector
// Block-averages the drifting theta omega word, scales it by sqrt(phi) and
// compares it against the SR1 omega word. A hysteretic FSM opens and closes
// alignment windows, pulses their start and end, and counts their length.
//   Latency: block-completing clk_en at edge N -> theta_avg at N,
//            abs_err/eval_valid at N+1, FSM outputs at N+2.
//   Backpressure: none; this is a free-running strobe pipeline, and clk_en
//                 may be asserted on every cycle.
// Optional feature macro: ALIGN_REFRACTORY_EN (adds the REFRACT hold state).
// Ports:
//   clk, rst       clock, asynchronous active-high reset
//   clk_en         sample strobe; inputs are sampled only when it is high
//   omega_theta    signed theta omega*dt (Q14)
//   omega_sr1      signed SR1 omega*dt (Q14), used on block-completing samples
//   eval_valid     one-clk pulse when abs_err updates
//   abs_err        |scaled theta - SR1|, saturated to 2^(WIDTH-1)-1
//   aligned        high in ALIGNED and EXIT
//   window_start   one-clk pulse on ENTER -> ALIGNED
//   window_end     one-clk pulse on EXIT timeout
//   window_len     evaluations spent in the current/last window (saturating)
//   state          FSM state: IDLE=0 ENTER=1 ALIGNED=2 EXIT=3 REFRACT=4
module theta_sr1_alignment_detector #(
  parameter int WIDTH          = 18,
  parameter int AVG_LOG2       = 4,
  parameter int RATIO_Q14      = 20841,
  parameter int TOL            = 4,
  parameter int ENTER_COUNT    = 8,
  parameter int EXIT_COUNT     = 4,
  parameter int REFRACT_BLOCKS = 16
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    clk_en,
  input  logic signed [WIDTH-1:0] omega_theta,
  input  logic signed [WIDTH-1:0] omega_sr1,
  output logic                    eval_valid,
  output logic        [WIDTH-1:0] abs_err,
  output logic                    aligned,
  output logic                    window_start,
  output logic                    window_end,
  output logic        [15:0]      window_len,
  output logic        [2:0]       state
);

  localparam int ACC_W  = WIDTH + AVG_LOG2;
  // Full product width: signed theta times a 16-bit unsigned ratio.
  localparam int PROD_W = WIDTH + 17;

  localparam logic [WIDTH-1:0]  TOL_W     = WIDTH'(TOL);
  localparam logic [7:0]        ENTER_C   = 8'(ENTER_COUNT);
  localparam logic [7:0]        EXIT_C    = 8'(EXIT_COUNT);
  localparam logic [PROD_W-1:0] SAT_MAX_P = {{(PROD_W-WIDTH+1){1'b0}}, {(WIDTH-1){1'b1}}};
  localparam logic [WIDTH-1:0]  SAT_MAX   = {1'b0, {(WIDTH-1){1'b1}}};

  // Elaboration-time legality checks on the configuration.
  if (AVG_LOG2 < 1 || AVG_LOG2 > 8 || ENTER_COUNT < 2 || ENTER_COUNT > 255 ||
      EXIT_COUNT < 2 || EXIT_COUNT > 255 || REFRACT_BLOCKS < 1 ||
      RATIO_Q14 < 0 || RATIO_Q14 > 65535 || TOL < 0) begin : g_bad_params
    $error("theta_sr1_alignment_detector: illegal parameter value");
  end

  typedef enum logic [2:0] {
    S_IDLE    = 3'd0,
    S_ENTER   = 3'd1,
    S_ALIGNED = 3'd2,
    S_EXIT    = 3'd3,
    S_REFRACT = 3'd4
  } state_t;

  // ---------------------------------------------------------------- stage 1
  logic signed [ACC_W-1:0]  acc;
  logic signed [ACC_W-1:0]  acc_sum;
  logic        [AVG_LOG2-1:0] sample_cnt;
  logic signed [WIDTH-1:0]  theta_avg;
  logic signed [WIDTH-1:0]  sr1_cap;
  logic                     avg_vld;

  assign acc_sum = acc + {{AVG_LOG2{omega_theta[WIDTH-1]}}, omega_theta};

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      acc        <= '0;
      sample_cnt <= '0;
      theta_avg  <= '0;
      sr1_cap    <= '0;
      avg_vld    <= 1'b0;
    end else begin
      avg_vld <= 1'b0;
      if (clk_en) begin
        sample_cnt <= sample_cnt + 1'b1;
        if (&sample_cnt) begin
          // Arithmetic shift floors; the mean of WIDTH-bit samples fits WIDTH bits.
          theta_avg <= WIDTH'(acc_sum >>> AVG_LOG2);
          sr1_cap   <= omega_sr1;
          acc       <= '0;
          avg_vld   <= 1'b1;
        end else begin
          acc <= acc_sum;
        end
      end
    end
  end

  // ---------------------------------------------------------------- stage 2
  logic signed [PROD_W-1:0] avg_ext;
  logic signed [PROD_W-1:0] sr1_ext;
  logic signed [PROD_W-1:0] prod;
  logic signed [PROD_W-1:0] err;
  logic        [PROD_W-1:0] mag;
  logic        [WIDTH-1:0]  abs_next;

  assign avg_ext = {{(PROD_W-WIDTH){theta_avg[WIDTH-1]}}, theta_avg};
  assign sr1_ext = {{(PROD_W-WIDTH){sr1_cap[WIDTH-1]}}, sr1_cap};
  assign prod    = avg_ext * PROD_W'(RATIO_Q14);
  // The error is kept at full product width so a large scaled theta cannot
  // wrap before saturation.
  assign err      = (prod >>> 14) - sr1_ext;
  assign mag      = err[PROD_W-1] ? $unsigned(-err) : $unsigned(err);
  assign abs_next = (mag > SAT_MAX_P) ? SAT_MAX : mag[WIDTH-1:0];

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      eval_valid <= 1'b0;
      abs_err    <= '0;
    end else begin
      eval_valid <= avg_vld;
      if (avg_vld) begin
        abs_err <= abs_next;
      end
    end
  end

  // ---------------------------------------------------------------- FSM
  logic        in_tol;
  state_t      state_q, state_d;
  logic [7:0]  cnt_q, cnt_d;
  logic [15:0] len_q, len_d, len_inc;
  logic        start_q, start_d;
  logic        end_q, end_d;

  assign in_tol  = (abs_err <= TOL_W);
  assign len_inc = (len_q == 16'hFFFF) ? len_q : len_q + 16'd1;

`ifdef ALIGN_REFRACTORY_EN
  localparam logic [15:0] REFRACT_C = 16'(REFRACT_BLOCKS);
  logic [15:0] refr_q, refr_d;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      refr_q <= '0;
    end else begin
      refr_q <= refr_d;
    end
  end
`endif

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= S_IDLE;
      cnt_q   <= '0;
      len_q   <= '0;
      start_q <= 1'b0;
      end_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      len_q   <= len_d;
      start_q <= start_d;
      end_q   <= end_d;
    end
  end

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    len_d   = len_q;
    start_d = 1'b0;
    end_d   = 1'b0;
`ifdef ALIGN_REFRACTORY_EN
    refr_d  = refr_q;
`endif
    if (eval_valid) begin
      case (state_q)
        S_IDLE: begin
          if (in_tol) begin
            state_d = S_ENTER;
            cnt_d   = 8'd1;
          end
        end
        S_ENTER: begin
          if (!in_tol) begin
            state_d = S_IDLE;
          end else if (cnt_q + 8'd1 == ENTER_C) begin
            state_d = S_ALIGNED;
            start_d = 1'b1;
            len_d   = '0;
          end else begin
            cnt_d = cnt_q + 8'd1;
          end
        end
        S_ALIGNED: begin
          len_d = len_inc;
          if (!in_tol) begin
            state_d = S_EXIT;
            cnt_d   = 8'd1;
          end
        end
        S_EXIT: begin
          // The timeout evaluation itself still counts toward window_len.
          len_d = len_inc;
          if (in_tol) begin
            state_d = S_ALIGNED;
            cnt_d   = 8'd0;
          end else if (cnt_q + 8'd1 == EXIT_C) begin
            end_d = 1'b1;
`ifdef ALIGN_REFRACTORY_EN
            state_d = S_REFRACT;
            refr_d  = '0;
`else
            state_d = S_IDLE;
`endif
          end else begin
            cnt_d = cnt_q + 8'd1;
          end
        end
`ifdef ALIGN_REFRACTORY_EN
        S_REFRACT: begin
          // in_tol is deliberately ignored while refractory.
          if (refr_q + 16'd1 == REFRACT_C) begin
            state_d = S_IDLE;
          end else begin
            refr_d = refr_q + 16'd1;
          end
        end
`endif
        default: state_d = S_IDLE;
      endcase
    end
  end

  assign state        = state_q;
  assign aligned      = (state_q == S_ALIGNED) || (state_q == S_EXIT);
  assign window_start = start_q;
  assign window_end   = end_q;
  assign window_len   = len_q;

endmodule
